vsp_outport_fifo: RTL and testbench
===================================

Name: vsp_outport_fifo

Overview:
- Output-port buffer directly downstream of the vsprocessor core.
- Captures each byte the core writes to its output port (outdata, qualified by a one-cycle write strobe) into a small FIFO.
- Presents bytes to a downstream consumer (display/serial driver) over a valid/ready handshake, so a slow consumer never misses a core write until the FIFO fills.
- Lossy-when-full behaviour is flagged by a sticky overflow bit.

Parameters:
- DATA_W, 8, width of outdata and of each FIFO entry.
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- out_we  input  1  core output-write strobe; one cycle per byte written.
- outdata  input  DATA_W  byte from core output register, valid when out_we=1.
- rd_valid  output  1  FIFO head is valid.
- rd_data  output  DATA_W  FIFO head byte; 0 when rd_valid=0.
- rd_ready  input  1  consumer accepts head this cycle.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was dropped because FIFO was full.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Hence rd_valid=0, rd_data=0, full=0. Storage array is not reset.
- Reset mid-operation discards all contents immediately, with no clock needed. Release is synchronous to the next clk edge.
- pop = rd_valid & rd_ready.
- push = out_we & (~full | pop).
  - When full, a simultaneous pop frees the slot, so the write is accepted.
- On push: mem[wr_ptr] <= outdata; wr_ptr <= wr_ptr+1.
- On pop: rd_ptr <= rd_ptr+1.
- Pointers wrap modulo DEPTH.
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both, or neither: unchanged.
- First-word fall-through:
  - rd_data = mem[rd_ptr] combinationally when count != 0, else 0.
  - rd_valid = (count != 0).
  - full = (count == DEPTH).
- Latency: a byte written at edge N is visible on rd_valid/rd_data after edge N (cycle N+1). A pop at edge M exposes the next entry in cycle M+1.
- Empty + out_we + rd_ready in the same cycle: no bypass. The byte is stored, and pop=0 because rd_valid=0.
- rd_ready while empty: ignored; no pointer movement.
- Full + out_we + no pop: byte dropped, contents unchanged, overflow <= 1.
- overflow is cleared only by rst.
- Handshake rule: consumer must not assume rd_data holds after a pop edge.
- While rd_valid=1 and rd_ready=0, rd_data and rd_valid hold stable; new pushes never alter the head.
- No combinational path from rd_ready to rd_valid. rd_data depends only on registered state.

Test Plan:
- Reset hold: rst=1 with out_we pulses -> count=0, rd_valid=0, rd_data=0, overflow=0 throughout; rst=0 -> still empty.
- Single byte: out_we=1, outdata=8'd12 for one cycle, rd_ready=0 -> next cycle rd_valid=1, rd_data=12, count=1. Then rd_ready=1 for one cycle -> count=0, rd_valid=0.
- Fill and wrap: push 8'h11,8'h22,8'h33,8'h44 with rd_ready=0 -> full=1, count=4. Push 8'h55 -> dropped, overflow=1. Drain -> 11,22,33,44 in order. Push 8'h66 -> stored at wrapped slot 0, read back as 66.
- Simultaneous push/pop when full: count=4, head 8'hA0; out_we=1 with outdata=8'hB0 and rd_ready=1 -> count stays 4, overflow unchanged, next head 8'hA1, B0 becomes last entry.
- Empty simultaneous: count=0, out_we=1 with outdata=8'h7E and rd_ready=1 -> count=1, rd_valid=1 next cycle, rd_data=7E.
- Async reset mid-stream: count=3, overflow=1, assert rst between clock edges -> count=0, rd_valid=0, overflow=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/vsp_outport_fifo.sv
// vsp_outport_fifo
// Output-port buffer downstream of the vsprocessor core. Each byte the core
// writes (outdata qualified by out_we) is captured into a small FIFO and
// offered to a downstream consumer over a valid/ready handshake with
// first-word fall-through. A write that arrives while the FIFO is full, and
// is not paired with a pop, is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset (control state only)
//   out_we   - core output-write strobe, one cycle per byte
//   outdata  - byte from the core output register
//   rd_valid - FIFO head is valid
//   rd_data  - FIFO head byte, 0 when rd_valid=0
//   rd_ready - consumer accepts the head this cycle
//   full     - occupancy equals DEPTH
//   count    - occupancy, 0..DEPTH
//   overflow - sticky: a write was dropped while full
module vsp_outport_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_we,
  input  logic [DATA_W-1:0] outdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // Status and head are derived from registered state only, so rd_ready has
  // no combinational path to rd_valid or rd_data.
  assign rd_valid = (count != '0);
  assign full     = (count == DEPTH_C);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // A pop while full frees the slot, so a simultaneous write is accepted.
  assign pop  = rd_valid & rd_ready;
  assign push = out_we & (~full | pop);

  // Storage: not reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= outdata;
    end
  end

  // Control state: pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (ADDR_W+1)'(1);
      end
      if (out_we && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vsp_outport_fifo.sv
// Testbench for vsp_outport_fifo: directed vector table, hand-written reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_vsp_outport_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              out_we;
  logic [DATA_W-1:0] outdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int n_pass  = 0;
  int n_total = 0;

  vsp_outport_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .out_we  (out_we),
    .outdata (outdata),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_ready(rd_ready),
    .full    (full),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] data;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] ec;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [7:0] data, logic rdy, logic ev,
                              logic [7:0] ed, logic [2:0] ec, logic ef, logic eo);
    vec_t v;
    v.we = we; v.data = data; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                         input logic [2:0] ec, input logic ef, input logic eo);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(ev));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(ed));
    chk({tag, ".count"},    32'(count),    32'(ec));
    chk({tag, ".full"},     32'(full),     32'(ef));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
  endtask

  // Drive one cycle's inputs, clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [7:0] data, input logic rdy);
    out_we   = we;
    outdata  = data;
    rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    byte unsigned q[$];
    logic         m_ovf;
    logic         we, rdy, pop, push;
    logic [7:0]   d;

    rst = 1'b1; out_we = 1'b0; outdata = '0; rd_ready = 1'b0;
    #1;
    chk_all("reset_initial", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset hold: writes are ignored while rst is asserted.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'hC0 + i), 1'b0);
      chk_all("reset_hold", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    end
    #2 rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    chk_all("reset_release", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Directed vectors: inputs for one cycle, expected outputs after the edge.
    tbl.push_back(mk(1, 8'd12,  0, 1, 8'd12,  3'd1, 0, 0)); // single byte
    tbl.push_back(mk(0, 8'h00,  1, 0, 8'h00,  3'd0, 0, 0)); // pop it
    tbl.push_back(mk(0, 8'h00,  1, 0, 8'h00,  3'd0, 0, 0)); // ready while empty
    tbl.push_back(mk(1, 8'h11,  0, 1, 8'h11,  3'd1, 0, 0));
    tbl.push_back(mk(1, 8'h22,  0, 1, 8'h11,  3'd2, 0, 0)); // head stable
    tbl.push_back(mk(1, 8'h33,  0, 1, 8'h11,  3'd3, 0, 0));
    tbl.push_back(mk(1, 8'h44,  0, 1, 8'h11,  3'd4, 1, 0)); // full
    tbl.push_back(mk(1, 8'h55,  0, 1, 8'h11,  3'd4, 1, 1)); // dropped
    tbl.push_back(mk(0, 8'h00,  1, 1, 8'h22,  3'd3, 0, 1));
    tbl.push_back(mk(0, 8'h00,  1, 1, 8'h33,  3'd2, 0, 1));
    tbl.push_back(mk(0, 8'h00,  1, 1, 8'h44,  3'd1, 0, 1));
    tbl.push_back(mk(0, 8'h00,  1, 0, 8'h00,  3'd0, 0, 1));
    tbl.push_back(mk(1, 8'h66,  0, 1, 8'h66,  3'd1, 0, 1)); // wrapped slot
    tbl.push_back(mk(0, 8'h00,  1, 0, 8'h00,  3'd0, 0, 1));
    tbl.push_back(mk(1, 8'h7E,  1, 1, 8'h7E,  3'd1, 0, 1)); // empty + we + ready
    tbl.push_back(mk(0, 8'h00,  1, 0, 8'h00,  3'd0, 0, 1));
    tbl.push_back(mk(1, 8'hA0,  0, 1, 8'hA0,  3'd1, 0, 1));
    tbl.push_back(mk(1, 8'hA1,  0, 1, 8'hA0,  3'd2, 0, 1));
    tbl.push_back(mk(1, 8'hA2,  0, 1, 8'hA0,  3'd3, 0, 1));
    tbl.push_back(mk(1, 8'hA3,  0, 1, 8'hA0,  3'd4, 1, 1));
    tbl.push_back(mk(1, 8'hB0,  1, 1, 8'hA1,  3'd4, 1, 1)); // full push+pop
    tbl.push_back(mk(0, 8'h00,  1, 1, 8'hA2,  3'd3, 0, 1));
    tbl.push_back(mk(0, 8'h00,  1, 1, 8'hA3,  3'd2, 0, 1));
    tbl.push_back(mk(0, 8'h00,  1, 1, 8'hB0,  3'd1, 0, 1));
    tbl.push_back(mk(0, 8'h00,  1, 0, 8'h00,  3'd0, 0, 1));

    foreach (tbl[i]) begin
      cyc(tbl[i].we, tbl[i].data, tbl[i].rdy);
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].eo);
    end

    // Async reset mid-stream: three entries held, overflow set.
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    out_we = 1'b0;
    chk_all("pre_async_rst", 1'b1, 8'h01, 3'd3, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);
    chk_all("async_rst_release", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Randomized traffic against a queue model of the FIFO.
    m_ovf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
      d   = 8'($urandom);
      pop  = (q.size() != 0) && rdy;
      push = we && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      else if (we) m_ovf = 1'b1;
      cyc(we, d, rdy);
      chk_all($sformatf("rand%0d", i), q.size() != 0,
              (q.size() != 0) ? q[0] : 8'h00,
              3'(q.size()), q.size() == DEPTH, m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
